alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_if.sv | 27 ++
 rtl/alu_exec.sv | 153 +++++++++++++++
 tb/tb_alu_exec.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Launch/operand/result bundle for alu_exec.
// The sequencer side drives the launch fields and the ALU answers on the rest.
interface alu_exec_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [3:0]       aluCnt;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             flush;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic             zero;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, aluCnt, opA, opB, flush,
      input  result, hi, zero, busy, done, err
   );

   modport slave (
      input  start, aluCnt, opA, opB, flush,
      output result, hi, zero, busy, done, err
   );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring divide that each take WIDTH cycles.
module alu_exec #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   alu_exec_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_PASSB = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_NOR   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opnd_q;
   // {hi half, lo half}: product/multiplier for MUL, remainder/quotient for DIV
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   result_q, hi_q;
   logic               zero_q, done_q, err_q;

   logic               launch, last, is_mul, is_div_iter;
   logic               busy;
   logic [WIDTH-1:0]   alu_r, alu_h;
   logic               alu_e;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, step_next;

   assign launch      = bus.start && !bus.flush && (state_q == S_IDLE);
   assign is_mul      = (bus.aluCnt == OP_MUL);
   assign is_div_iter = (bus.aluCnt == OP_DIV) && (bus.opB != '0);
   assign last        = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (launch && is_mul)           state_d = S_MUL;
            else if (launch && is_div_iter) state_d = S_DIV;
         end
         S_MUL, S_DIV: if (bus.flush || last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statements can leave a latch behind.
      busy  = (state_q != S_IDLE);
      alu_r = '0;
      alu_h = '0;
      alu_e = 1'b0;
      case (bus.aluCnt)
         OP_ADD:   alu_r = bus.opA + bus.opB;
         OP_SUB:   alu_r = bus.opA - bus.opB;
         OP_PASSB: alu_r = bus.opB;
         OP_AND:   alu_r = bus.opA & bus.opB;
         OP_OR:    alu_r = bus.opA | bus.opB;
         OP_XOR:   alu_r = bus.opA ^ bus.opB;
         OP_NOR:   alu_r = ~(bus.opA | bus.opB);
         OP_SLT:   alu_r = ($signed(bus.opA) < $signed(bus.opB)) ? WIDTH'(1) : '0;
         OP_MUL:   alu_r = '0;
         OP_DIV: begin
            // only reaches the outputs for a zero divisor
            alu_r = '1;
            alu_h = bus.opA;
            alu_e = 1'b1;
         end
         default:  alu_e = 1'b1;
      endcase

      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
      step_next = (state_q == S_MUL) ? mul_next : div_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: every register, including the scratch operand/counter, has a
      // reset value so an abandoned operation leaves nothing behind.
      if (!rst) begin
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == S_IDLE) begin
            if (launch) begin
               cnt_q <= '0;
               if (is_mul) begin
                  acc_q  <= {{WIDTH{1'b0}}, bus.opB};
                  opnd_q <= bus.opA;
               end else if (is_div_iter) begin
                  acc_q  <= {{WIDTH{1'b0}}, bus.opA};
                  opnd_q <= bus.opB;
               end else begin
                  result_q <= alu_r;
                  hi_q     <= alu_h;
                  zero_q   <= (alu_r == '0);
                  err_q    <= alu_e;
                  done_q   <= 1'b1;
               end
            end
         end else if (!bus.flush) begin
            acc_q <= step_next;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
               cnt_q    <= '0;
               result_q <= step_next[WIDTH-1:0];
               hi_q     <= step_next[2*WIDTH-1:WIDTH];
               zero_q   <= (step_next[WIDTH-1:0] == '0);
               err_q    <= 1'b0;
               done_q   <= 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign bus.result = result_q;
   assign bus.hi     = hi_q;
   assign bus.zero   = zero_q;
   assign bus.busy   = busy;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, randomized ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_alu_exec;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   alu_exec_if #(.WIDTH(W)) bus();
   alu_exec #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   code;
      logic [W-1:0] a, b, r, h;
      logic         z, e;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void ref_model(input logic [3:0] c, input logic [W-1:0] a, b,
                                     output logic [W-1:0] r, h, output logic e);
      logic [2*W-1:0] p;
      r = '0; h = '0; e = 1'b0;
      case (c)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = b;
         4'd3:  r = a & b;
         4'd4:  r = a | b;
         4'd5:  r = a ^ b;
         4'd6:  r = ~(a | b);
         4'd7:  r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
         4'd12: begin p = 32'(a) * 32'(b); r = p[W-1:0]; h = p[2*W-1:W]; end
         4'd14: begin
            if (b == 0) begin r = '1; h = a; e = 1'b1; end
            else begin r = a / b; h = a % b; end
         end
         default: e = 1'b1;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] code, input logic [W-1:0] a, b,
                         input logic [W-1:0] er, eh, input logic ez, ee, input string tag);
      int k;
      int lat;
      lat = (code == 4'hC || (code == 4'hE && b != 0)) ? W : 0;
      bus.start = 1'b1; bus.aluCnt = code; bus.opA = a; bus.opB = b;
      step();
      bus.start = 1'b0; bus.opA = ~a; bus.opB = $urandom;
      k = 0;
      while (!bus.done && k < 100) begin
         step();
         k++;
      end
      check({tag, " latency"}, k, lat);
      check({tag, " result"}, bus.result, er);
      check({tag, " hi"}, bus.hi, eh);
      check({tag, " zero"}, bus.zero, ez);
      check({tag, " err"}, bus.err, ee);
      check({tag, " busy"}, bus.busy, 0);
      step();
      check({tag, " done pulse"}, bus.done, 0);
   endtask

   initial begin
      logic [3:0]   codes[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                  4'd12, 4'd14, 4'd8, 4'd15};
      logic [W-1:0] mr, mh, ra, rb;
      logic         me;
      int           k;
      bit           saw_done;

      vecs[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{4'h7, 16'h8000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[3]  = '{4'hC, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 1'b0};
      vecs[4]  = '{4'hE, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
      vecs[5]  = '{4'hE, 16'h0050, 16'h0000, 16'hFFFF, 16'h0050, 1'b0, 1'b1};
      vecs[6]  = '{4'h3, 16'hFF0F, 16'h0FF0, 16'h0F00, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{4'h4, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 1'b0};
      vecs[8]  = '{4'h5, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b0};
      vecs[9]  = '{4'h6, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
      vecs[10] = '{4'h2, 16'h1234, 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0};
      vecs[11] = '{4'h9, 16'h1000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1};
      vecs[12] = '{4'hC, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0};

      bus.start = 1'b0; bus.aluCnt = '0; bus.opA = '0; bus.opB = '0; bus.flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst result", bus.result, 0);
      check("rst hi", bus.hi, 0);
      check("rst zero", bus.zero, 1);
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst err", bus.err, 0);
      rst = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].h,
                vecs[i].z, vecs[i].e, $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         logic [3:0] c;
         c  = codes[$urandom_range(0, 11)];
         ra = $urandom;
         rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
         ref_model(c, ra, rb, mr, mh, me);
         run_op(c, ra, rb, mr, mh, (mr == 0), me, $sformatf("rand%0d op%0h", i, c));
      end

      // start held through a whole MUL: ignored until after completion
      bus.start = 1'b1; bus.aluCnt = 4'hC; bus.opA = 16'd3; bus.opB = 16'd5;
      step();
      bus.aluCnt = 4'h0; bus.opA = 16'd10; bus.opB = 16'd20;
      k = 0;
      while (!bus.done && k < 100) begin step(); k++; end
      check("held start latency", k, W);
      check("held start mul result", bus.result, 15);
      step();
      check("held start add done", bus.done, 1);
      check("held start add result", bus.result, 30);
      bus.start = 1'b0;
      step();
      check("held start done drop", bus.done, 0);

      // flush mid-MUL with stray start pulses
      run_op(4'h0, 16'd3, 16'd4, 16'd7, 16'd0, 1'b0, 1'b0, "pre flush add");
      bus.start = 1'b1; bus.aluCnt = 4'hC; bus.opA = 16'h1234; bus.opB = 16'h0100;
      step();
      for (int i = 1; i < 5; i++) begin
         bus.start = i[0]; bus.aluCnt = 4'h0; bus.opA = $urandom;
         step();
      end
      check("flush busy before", bus.busy, 1);
      bus.flush = 1'b1; bus.start = 1'b1;
      step();
      bus.flush = 1'b0; bus.start = 1'b0;
      check("flush busy", bus.busy, 0);
      check("flush done", bus.done, 0);
      check("flush result", bus.result, 7);
      check("flush hi", bus.hi, 0);
      check("flush err", bus.err, 0);
      run_op(4'h0, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, 1'b0, "post flush add");
      saw_done = 1'b0;
      repeat (20) begin step(); if (bus.done) saw_done = 1'b1; end
      check("flush stray done", saw_done, 0);

      // flush beats start in IDLE
      bus.start = 1'b1; bus.flush = 1'b1; bus.aluCnt = 4'hC; bus.opA = 16'd9; bus.opB = 16'd9;
      step();
      check("idle flush mul busy", bus.busy, 0);
      bus.aluCnt = 4'h0;
      step();
      bus.start = 1'b0; bus.flush = 1'b0;
      check("idle flush add done", bus.done, 0);
      check("idle flush add result", bus.result, 2);

      // reset in the middle of a DIV
      bus.start = 1'b1; bus.aluCnt = 4'hE; bus.opA = 16'd100; bus.opB = 16'd7;
      step();
      bus.start = 1'b0;
      repeat (7) step();
      check("div busy before rst", bus.busy, 1);
      #2 rst = 1'b0;
      #1;
      check("mid rst result", bus.result, 0);
      check("mid rst hi", bus.hi, 0);
      check("mid rst zero", bus.zero, 1);
      check("mid rst busy", bus.busy, 0);
      check("mid rst done", bus.done, 0);
      check("mid rst err", bus.err, 0);
      step();
      rst = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin step(); if (bus.done || bus.busy) saw_done = 1'b1; end
      check("after rst quiet", saw_done, 0);
      run_op(4'h0, 16'd2, 16'd2, 16'd4, 16'd0, 1'b0, 1'b0, "after rst add");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
